// File: rtl/uart_rx.sv
// 8N1 UART receiver. Oversamples the asynchronous rx line with the core clock,
// aligns to the middle of the start bit, then samples every data and stop bit
// at mid-bit. Good frames raise a one-cycle valid strobe with the byte on data;
// a low stop bit raises a one-cycle frame_err and waits for the line to idle.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] CNT_MID  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t               state, state_nxt;
  logic                 rx_meta, rx_s;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 take_bit, good_frame, bad_frame;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (!areset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking so both stages shift on the same edge; blocking
      // assignments here would collapse the chain into a single flop.
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!areset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode and per-cycle datapath controls.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a variable unassigned and infers a latch.
    state_nxt  = state;
    take_bit   = 1'b0;
    good_frame = 1'b0;
    bad_frame  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx_s) state_nxt = ST_START;
      end
      ST_START: begin
        // Half a bit into the start bit: a high line means it was a glitch.
        if (cnt == CNT_MID) state_nxt = rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (cnt == CNT_END) begin
          take_bit = 1'b1;
          if (bit_idx == IDX_LAST) state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leaving at the stop midpoint gives half a bit to catch the next start.
        if (cnt == CNT_END) begin
          if (rx_s) begin
            good_frame = 1'b1;
            state_nxt  = ST_IDLE;
          end else begin
            bad_frame  = 1'b1;
            state_nxt  = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // Held-low line: stay put until it returns high.
        if (rx_s) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Baud counter, bit index, shift register and registered strobes.
  always_ff @(posedge clk) begin
    if (!areset) begin
      cnt       <= '0;
      bit_idx   <= '0;
      // NOTE: the shift register is reset along with the counters; it is only
      // a handful of flops and keeps data deterministic after any reset.
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= good_frame;
      frame_err <= bad_frame;

      if (state_nxt != state || state == ST_IDLE || state == ST_BREAK || take_bit)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (state != ST_DATA) bit_idx <= '0;
      else if (take_bit)    bit_idx <= bit_idx + 1'b1;

      if (take_bit)   shreg[bit_idx] <= rx_s;
      if (good_frame) data           <= shreg;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at 16 clocks/bit for the functional
// scenarios, one at 5 clocks/bit for the odd-divisor latency case.
module tb_uart_rx;

  localparam int NA = 16;
  localparam int NB = 5;

  logic       clk = 1'b0;
  logic       areset_a, rx_a, valid_a, frame_err_a, busy_a;
  logic       areset_b, rx_b, valid_b, frame_err_b, busy_b;
  logic [7:0] data_a, data_b;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(NA), .DATA_BITS(8)) dut_a (
    .clk       (clk),
    .areset    (areset_a),
    .rx        (rx_a),
    .data      (data_a),
    .valid     (valid_a),
    .frame_err (frame_err_a),
    .busy      (busy_a)
  );

  uart_rx #(.CLKS_PER_BIT(NB), .DATA_BITS(8)) dut_b (
    .clk       (clk),
    .areset    (areset_b),
    .rx        (rx_b),
    .data      (data_b),
    .valid     (valid_b),
    .frame_err (frame_err_b),
    .busy      (busy_b)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         va_cnt = 0;
  int         ea_cnt = 0;
  int         both_cnt = 0;
  int         busy_a_cycles = 0;
  int         vb_cnt = 0;
  int         eb_cnt = 0;
  int         cyc = 0;
  int         tb_start = -1;
  int         tb_valid = -1;
  logic       busy_b_q = 1'b0;
  logic [7:0] qa[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (valid_a) begin
      va_cnt++;
      qa.push_back(data_a);
    end
    if (frame_err_a) ea_cnt++;
    if ((valid_a && frame_err_a) || (valid_b && frame_err_b)) both_cnt++;
    if (busy_a) busy_a_cycles++;
    if (busy_b && !busy_b_q && tb_start < 0) tb_start = cyc;
    busy_b_q = busy_b;
    if (valid_b) begin
      vb_cnt++;
      if (tb_valid < 0) tb_valid = cyc;
    end
    if (frame_err_b) eb_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pop_a();
    if (qa.size() > 0) return {24'h0, qa.pop_front()};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic idle_a(input int n);
    rx_a = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Frame = start(0), data LSB first, stop.
  task automatic send_a(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_a = f[i];
      repeat (NA) @(negedge clk);
    end
  endtask

  task automatic send_b(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_b = f[i];
      repeat (NB) @(negedge clk);
    end
  endtask

  initial begin
    logic [9:0] f;
    int         lat;

    areset_a = 1'b0;
    areset_b = 1'b0;
    rx_a     = 1'b1;
    rx_b     = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_data",  {24'h0, data_a}, 32'h0);
    check("rst_valid", {31'h0, valid_a}, 32'h0);
    check("rst_ferr",  {31'h0, frame_err_a}, 32'h0);
    check("rst_busy",  {31'h0, busy_a}, 32'h0);
    check("rst_data_b", {24'h0, data_b}, 32'h0);
    areset_a = 1'b1;
    areset_b = 1'b1;
    idle_a(20);

    // Single frame 0xA5; busy spans start detect to stop midpoint (8+1+144).
    busy_a_cycles = 0;
    send_a(8'hA5, 1'b1);
    idle_a(20);
    check("a5_nvalid", va_cnt, 1);
    check("a5_byte",   pop_a(), 32'hA5);
    check("a5_data",   {24'h0, data_a}, 32'hA5);
    check("a5_ferr",   ea_cnt, 0);
    check("a5_busy_len_ok", {31'h0, (busy_a_cycles >= 151 && busy_a_cycles <= 153)}, 32'h1);
    check("a5_idle",   {31'h0, busy_a}, 32'h0);

    // Back-to-back frames with no idle time between them.
    send_a(8'h00, 1'b1);
    send_a(8'hFF, 1'b1);
    send_a(8'h3C, 1'b1);
    idle_a(40);
    check("b2b_nvalid", va_cnt, 4);
    check("b2b_byte0",  pop_a(), 32'h00);
    check("b2b_byte1",  pop_a(), 32'hFF);
    check("b2b_byte2",  pop_a(), 32'h3C);
    check("b2b_ferr",   ea_cnt, 0);

    // Short low glitch: brief busy, no strobes, then a normal frame.
    busy_a_cycles = 0;
    rx_a = 1'b0;
    repeat (4) @(negedge clk);
    idle_a(30);
    check("glitch_busy_seen", {31'h0, (busy_a_cycles > 0 && busy_a_cycles <= NA)}, 32'h1);
    check("glitch_nvalid", va_cnt, 4);
    check("glitch_ferr",   ea_cnt, 0);
    check("glitch_idle",   {31'h0, busy_a}, 32'h0);
    send_a(8'h5A, 1'b1);
    idle_a(20);
    check("5a_nvalid", va_cnt, 5);
    check("5a_byte",   pop_a(), 32'h5A);

    // Bad stop bit followed by a held-low line (break), then recovery.
    send_a(8'h81, 1'b0);
    rx_a = 1'b0;
    repeat (3 * NA) @(negedge clk);
    check("brk_ferr",   ea_cnt, 1);
    check("brk_nvalid", va_cnt, 5);
    check("brk_data",   {24'h0, data_a}, 32'h5A);
    check("brk_busy",   {31'h0, busy_a}, 32'h1);
    idle_a(32);
    check("brk_release", {31'h0, busy_a}, 32'h0);
    send_a(8'h42, 1'b1);
    idle_a(20);
    check("42_nvalid", va_cnt, 6);
    check("42_byte",   pop_a(), 32'h42);
    check("42_ferr",   ea_cnt, 1);

    // Reset in the middle of data bit 4 discards the frame.
    f = {1'b1, 8'h99, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx_a = f[i];
      repeat (NA) @(negedge clk);
    end
    rx_a = f[5];
    repeat (NA / 2) @(negedge clk);
    areset_a = 1'b0;
    rx_a     = 1'b1;
    repeat (3) @(negedge clk);
    areset_a = 1'b1;
    idle_a(40);
    check("abort_nvalid", va_cnt, 6);
    check("abort_ferr",   ea_cnt, 1);
    check("abort_data",   {24'h0, data_a}, 32'h0);
    check("abort_idle",   {31'h0, busy_a}, 32'h0);
    send_a(8'h99, 1'b1);
    idle_a(20);
    check("99_nvalid", va_cnt, 7);
    check("99_byte",   pop_a(), 32'h99);

    // Odd divisor: latency from start detect (busy rise) to valid is
    // (5-1)/2 + 1 + 8*5 + 5 = 48 cycles, +/-1.
    send_b(8'hC3);
    repeat (20) @(negedge clk);
    lat = tb_valid - tb_start;
    check("c3_nvalid", vb_cnt, 1);
    check("c3_data",   {24'h0, data_b}, 32'hC3);
    check("c3_ferr",   eb_cnt, 0);
    check("c3_latency_ok", {31'h0, (tb_start >= 0 && lat >= 47 && lat <= 49)}, 32'h1);

    check("strobes_exclusive", both_cnt, 0);
    check("no_extra_bytes",    qa.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the core's existing UART transmitter.
- Samples the asynchronous serial input `rx` in the core clock domain and reassembles bytes LSB-first.
- Presents each good byte with a one-cycle `valid` strobe and flags stop-bit errors.
- Sits beside the transmitter in the top level, clocked by the PLL output. It will feed a memory-mapped input register or the data path's load path.

Parameters:
- CLKS_PER_BIT, 434, core clock cycles per bit period (50 MHz / 115200); legal range ≥ 4.
- DATA_BITS, 8, data bits per frame; the `data` port width equals DATA_BITS.

Ports:
- clk  input  1  core clock; all logic on the rising edge.
- areset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- rx  input  1  asynchronous serial line; idle high.
- data  output  DATA_BITS  last correctly framed byte; bit 0 is the first received.
- valid  output  1  one-cycle pulse: `data` updated with a good frame this cycle.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high while in any state other than IDLE.

Behaviour:
- Reset (areset=0 at a clk edge):
  - state=IDLE; data=0, valid=0, frame_err=0, busy=0.
  - Bit counter and baud counter cleared; synchronizer flops set to 1 (idle line).
  - Applies mid-frame too: the partial frame is discarded and no strobe is issued.
- Input sync: `rx` passes through two flops; all decisions use the second-stage value (rx_s). Adds 2 cycles of latency.
- Baud counter: counts 0..CLKS_PER_BIT-1. Cleared on every state transition.
- States:
  - IDLE: busy=0. rx_s=0 → START.
  - START: when the counter reaches (CLKS_PER_BIT-1)/2 (integer division), check rx_s.
    - rx_s=0 → DATA, bit index=0.
    - rx_s=1 → glitch; return to IDLE with no strobe.
  - DATA: each time the counter reaches CLKS_PER_BIT-1, shift rx_s into the shift register at position `bit index` (LSB first). After bit DATA_BITS-1 → STOP.
  - STOP: when the counter reaches CLKS_PER_BIT-1, sample rx_s.
    - rx_s=1: data ← shift register; valid=1 for exactly that one cycle → IDLE.
    - rx_s=0: frame_err=1 for one cycle; data unchanged → BREAK.
  - BREAK: wait for rx_s=1, then → IDLE. Prevents a held-low line (break) from producing repeated frames or errors.
- Sampling point: every data and stop bit is sampled at mid-bit.
- Back-to-back frames: returning to IDLE at the stop-bit midpoint leaves half a bit period to catch the next start edge. Frames with zero idle time between them must all be received.
- Strobes: valid and frame_err are never high together. Each is high for exactly one cycle per frame. There is no ready/backpressure; a consumer that misses a strobe loses the byte, and data holds its value until the next good frame.
- Latency (N = CLKS_PER_BIT): valid rises (N-1)/2 + 1 + DATA_BITS·N + N cycles (±1) after the first clk edge that samples rx low.

Test Plan (CLKS_PER_BIT=16 unless noted):
- Reset then drive 0xA5 (start, 1,0,1,0,0,1,0,1, stop) → one valid pulse; data=0xA5; frame_err never high; busy high from start detect to stop midpoint.
- Drive 0x00, 0xFF, 0x3C back-to-back with zero idle bits → exactly three valid pulses, data = 0x00, 0xFF, 0x3C in order.
- Drive a 4-cycle low glitch on the idle line → busy pulses briefly; no valid, no frame_err; state back in IDLE; a following 0x5A frame is received correctly.
- Drive 0x81 with the stop bit low, then hold the line low for 3 bit times, then high, then 0x42 → one frame_err pulse; data keeps its previous value; no further strobes while low; then valid with data=0x42.
- Assert areset during bit 4 of a frame, release it, idle, then drive 0x99 → no strobe for the aborted frame; data=0 after reset; then valid with data=0x99.
- CLKS_PER_BIT=5 (odd), drive 0xC3 with the bit period exactly 5 cycles → data=0xC3; valid latency within ±1 cycle of formula.
